// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_reg_arbiter
//  Purpose  : Round-robin write arbiter in front of a shared W-bit register.
//             Up to N requesters present data; one winner per arbitration
//             loads the shared register and gets a one-cycle grant pulse.
//             Arbitrations alternate with a GRANT cycle, so at most one
//             write happens every two clocks.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous, active-high reset
//             req      - [N-1:0] level-held write requests
//             data_in  - [N*W-1:0] requester i data at [i*W +: W]
//             gnt      - [N-1:0] registered one-hot grant pulse
//             q        - [W-1:0] shared register contents
//             last_id  - [2:0] index of the most recent winner
//             wr_cnt   - [7:0] completed-write counter, wraps at 255
//  Revision : 1.0 - initial release
// ============================================================================
module rr_reg_arbiter #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] data_in,
   output logic [N-1:0]   gnt,
   output logic [W-1:0]   q,
   output logic [2:0]     last_id,
   output logic [7:0]     wr_cnt
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Requests and data are widened to the full 3-bit index space so the
   // winner index can select them directly for any legal N.
   localparam int         C_MAX_REQ  = 8;
   localparam logic [2:0] C_LAST_IDX = 3'(N - 1);

   state_t         r_state;
   state_t         w_state_next;
   logic [2:0]     r_ptr;

   logic [C_MAX_REQ-1:0] w_req_ext;
   logic [W-1:0]         w_slot [C_MAX_REQ];

   logic           w_any;
   logic [2:0]     w_win;
   logic [2:0]     w_ptr_next;
   logic [N-1:0]   w_gnt_next;
   logic           w_load;

   // -------------------------------------------------------------------------
   // Pad requests/data out to 8 slots; non-existent requesters never request.
   // -------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < C_MAX_REQ; i++) begin : g_slot
         if (i < N) begin : g_used
            assign w_req_ext[i] = req[i];
            assign w_slot[i]    = data_in[i*W +: W];
         end else begin : g_unused
            assign w_req_ext[i] = 1'b0;
            assign w_slot[i]    = '0;
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Rotating priority scan: offsets are walked from the lowest priority
   // (ptr+N-1) to the highest (ptr), so the last hit overwrites earlier ones
   // and the surviving winner is the first set bit starting at ptr.
   // -------------------------------------------------------------------------
   always_comb begin
      int s;
      w_win = r_ptr;
      w_any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         s = int'(r_ptr) + k;
         if (s >= N) begin
            s = s - N;
         end
         if (w_req_ext[3'(s)]) begin
            w_win = 3'(s);
            w_any = 1'b1;
         end
      end
   end

   // Priority moves to the requester just after the winner, wrapping N-1 -> 0.
   always_comb begin
      w_ptr_next = (w_win == C_LAST_IDX) ? 3'd0 : w_win + 3'd1;
   end

   always_comb begin
      w_gnt_next = '0;
      for (int i = 0; i < N; i++) begin
         w_gnt_next[i] = (w_win == 3'(i));
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_load       = 1'b1;
               w_state_next = GRANT;
            end
         end
         GRANT: begin
            // Requests are deliberately ignored here; a still-held request
            // is re-arbitrated in the next IDLE cycle at lowest priority.
            w_state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: shared register, grant pulse, winner id, pointer, counter.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q       <= '0;
         gnt     <= '0;
         last_id <= 3'd0;
         r_ptr   <= 3'd0;
         wr_cnt  <= 8'd0;
      end else begin
         if (w_load) begin
            q       <= w_slot[w_win];
            gnt     <= w_gnt_next;
            last_id <= w_win;
            r_ptr   <= w_ptr_next;
            wr_cnt  <= wr_cnt + 8'd1;
         end else begin
            gnt     <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_reg_arbiter
//  Purpose  : Directed self-checking bench for rr_reg_arbiter (N=4, W=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_reg_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] data_in;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic [2:0]     last_id;
   logic [7:0]     wr_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   rr_reg_arbiter #(.N(N), .W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .data_in (data_in),
      .gnt     (gnt),
      .q       (q),
      .last_id (last_id),
      .wr_cnt  (wr_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_gnt_seq [8];
   logic [3:0] val;
   logic [3:0] last_val;
   int         idx;

   initial begin
      exp_gnt_seq[0] = 4'b0001; exp_gnt_seq[1] = 4'b0000;
      exp_gnt_seq[2] = 4'b0010; exp_gnt_seq[3] = 4'b0000;
      exp_gnt_seq[4] = 4'b0100; exp_gnt_seq[5] = 4'b0000;
      exp_gnt_seq[6] = 4'b1000; exp_gnt_seq[7] = 4'b0000;
      last_val = 4'h0;

      // ---------------- reset state ----------------
      rst = 1'b1; req = '0; data_in = '0;
      tick; tick;
      check("rst_gnt",     32'(gnt),     32'h0);
      check("rst_q",       32'(q),       32'h0);
      check("rst_last_id", 32'(last_id), 32'h0);
      check("rst_wr_cnt",  32'(wr_cnt),  32'h0);
      rst = 1'b0;
      tick;
      check("idle_no_req_gnt", 32'(gnt), 32'h0);

      // ---------------- single requester ----------------
      req = 4'b0100; data_in = 16'h0A00;
      tick;
      check("single_gnt",     32'(gnt),     32'h4);
      check("single_q",       32'(q),       32'hA);
      check("single_last_id", 32'(last_id), 32'h2);
      check("single_wr_cnt",  32'(wr_cnt),  32'h1);
      req = 4'b0000;
      data_in = 16'h0500;       // change after the arbitration edge
      tick;
      check("single_gnt_drop", 32'(gnt), 32'h0);
      check("single_q_hold",   32'(q),   32'hA);

      // ---------------- pointer rotation (ptr = 3) ----------------
      req = 4'b0101; data_in = 16'h0C05;
      tick;
      check("rot_gnt",     32'(gnt),     32'h1);
      check("rot_q",       32'(q),       32'h5);
      check("rot_last_id", 32'(last_id), 32'h0);
      check("rot_wr_cnt",  32'(wr_cnt),  32'h2);
      req = 4'b0000;
      tick;
      check("rot_gnt_drop", 32'(gnt), 32'h0);

      // ---------------- reset mid-GRANT ----------------
      req = 4'b0001; data_in = 16'h0007;
      tick;
      check("midrst_pre_gnt", 32'(gnt), 32'h1);
      check("midrst_pre_q",   32'(q),   32'h7);
      #2 rst = 1'b1;
      #1;
      check("midrst_gnt",     32'(gnt),     32'h0);
      check("midrst_q",       32'(q),       32'h0);
      check("midrst_wr_cnt",  32'(wr_cnt),  32'h0);
      check("midrst_last_id", 32'(last_id), 32'h0);
      #1 rst = 1'b0;
      // Held request must win on the first edge: proves state is IDLE.
      tick;
      check("midrst_idle_gnt",    32'(gnt),    32'h1);
      check("midrst_idle_wr_cnt", 32'(wr_cnt), 32'h1);
      req = 4'b0000;
      tick;
      check("midrst_idle_drop", 32'(gnt), 32'h0);
      rst = 1'b1;
      #2 rst = 1'b0;

      // ---------------- full contention ----------------
      req = 4'b1111; data_in = 16'h4321;
      for (int i = 0; i < 8; i++) begin
         tick;
         check($sformatf("cont_gnt_%0d", i), 32'(gnt), 32'(exp_gnt_seq[i]));
      end
      check("cont_wr_cnt", 32'(wr_cnt), 32'h4);
      check("cont_q",      32'(q),      32'h4);
      tick;                     // pointer wrapped: requester 0 wins again
      check("cont_wrap_gnt",    32'(gnt),    32'h1);
      check("cont_wrap_q",      32'(q),      32'h1);
      check("cont_wrap_wr_cnt", 32'(wr_cnt), 32'h5);
      req = 4'b0000;
      tick;
      check("cont_end_gnt", 32'(gnt), 32'h0);

      // ---------------- counter wrap: 256 grants ----------------
      rst = 1'b1;
      #2 rst = 1'b0;
      for (int k = 0; k < 256; k++) begin
         idx      = k % N;
         val      = 4'(k) ^ 4'h5;
         req      = '0;
         req[idx] = 1'b1;
         data_in  = '0;
         data_in[idx*W +: W] = val;
         tick;
         check($sformatf("wrap_gnt_%0d", k), 32'(gnt), 32'(4'b0001 << idx));
         last_val = val;
         req      = '0;
         data_in[idx*W +: W] = ~val;   // ignored: only sampled on arbitration
         tick;
      end
      check("wrap_wr_cnt",  32'(wr_cnt),  32'h0);
      check("wrap_q",       32'(q),       32'(last_val));
      check("wrap_q_const", 32'(q),       32'hA);
      check("wrap_last_id", 32'(last_id), 32'h3);
      check("wrap_gnt",     32'(gnt),     32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
